// File: rtl/fpp_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fpp_ctrl_pkg
// Shared types and constants for the floating-point processor operation
// arbiter: sequencer state encoding, the opcode driven while no operation is
// active, the result reported for an abandoned operation, and the opcode
// field positions.
// ---------------------------------------------------------------------------
package fpp_ctrl_pkg;

   // Operation sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } fpp_state_e;

   // Opcode presented to the processor when no operation is in flight.
   localparam logic [7:0]  IDLE_OPCODE_DEF = 8'h00;

   // Result returned with err=1 when the processor never completes.
   localparam logic [15:0] TIMEOUT_RESULT  = 16'hFFFF;

   // Opcode layout: function[7:4], source[3:2], destination[1:0].
   localparam int OP_FUNC_HI = 7;
   localparam int OP_FUNC_LO = 4;
   localparam int OP_SRC_HI  = 3;
   localparam int OP_SRC_LO  = 2;
   localparam int OP_DST_HI  = 1;
   localparam int OP_DST_LO  = 0;

   // Extract the function field of an opcode.
   function automatic logic [3:0] op_func(input logic [7:0] op);
      return op[OP_FUNC_HI:OP_FUNC_LO];
   endfunction

endpackage

// File: rtl/fpp_rr_arb2.sv
// ---------------------------------------------------------------------------
// fpp_rr_arb2
// Two-way round-robin selector. When enabled and at least one request is
// high it names a winner; with both high the requester not granted last
// wins. The pointer moves past the winner whenever a grant is issued.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset (pointer favours requester 0)
//   req_i      request vector, bit N = requester N
//   arb_en_i   arbitration allowed this cycle
//   gnt_vld_o  a winner is selected this cycle
//   gnt_idx_o  index of the winner (valid with gnt_vld_o)
// ---------------------------------------------------------------------------
module fpp_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       arb_en_i,
   output logic       gnt_vld_o,
   output logic       gnt_idx_o
);

   // ptr_q names the requester that wins a tie.
   logic ptr_q;
   logic ptr_d;

   always_comb begin
      gnt_vld_o = arb_en_i & (|req_i);
      gnt_idx_o = 1'b0;
      if (&req_i) begin
         gnt_idx_o = ptr_q;
      end else begin
         gnt_idx_o = req_i[1];
      end
      ptr_d = ptr_q;
      if (gnt_vld_o) begin
         ptr_d = ~gnt_idx_o;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/fpp_op_arbiter.sv
// ---------------------------------------------------------------------------
// fpp_op_arbiter
// Grants the 16-bit floating-point processor to one of two requesters,
// sequences the operation (ISSUE -> WAIT -> RESP), controls the shared data
// bus and returns result / timeout status to the granted requester.
//
// Handshake: a requester holds reqN high until gntN pulses for one cycle;
// at that point opN/wdataN have been latched and may change. doneN pulses
// for one cycle when the operation ends; rdata and err are valid in that
// cycle and hold until the next completion. A reqN still high in IDLE
// after its doneN is a fresh request.
//
// Ports
//   clk, rst            clock (rising edge), async active-low reset
//   req0/1, op0/1       requests and opcodes (func[7:4] src[3:2] dst[1:0])
//   wdata0/1            operand driven onto the processor bus at ISSUE
//   gnt0/1, done0/1     one-cycle grant / completion pulses
//   rdata, err          result and timeout flag, valid with doneN
//   busy                high in every state except IDLE
//   fpp_opcode          opcode to the processor
//   fpp_bus_out/_oe     bus drive value and tristate enable
//   fpp_bus_in          sampled processor bus
//   fpp_flag            processor is driving the bus
//   fpp_done            processor finished (pulse)
//   dbg_state_o         current sequencer state
// ---------------------------------------------------------------------------
module fpp_op_arbiter
   import fpp_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT     = 64,
   parameter logic [7:0]  IDLE_OPCODE = IDLE_OPCODE_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [7:0]  op0,
   input  logic [7:0]  op1,
   input  logic [15:0] wdata0,
   input  logic [15:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic [15:0] rdata,
   output logic        err,
   output logic        busy,
   output logic [7:0]  fpp_opcode,
   output logic [15:0] fpp_bus_out,
   output logic        fpp_bus_oe,
   input  logic [15:0] fpp_bus_in,
   input  logic        fpp_flag,
   input  logic        fpp_done,
   output fpp_state_e  dbg_state_o
);

   localparam int            TW        = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

   fpp_state_e    state_q,   state_d;
   logic          owner_q,   owner_d;
   logic [15:0]   result_q,  result_d;
   logic [TW-1:0] timer_q,   timer_d;
   logic          gnt0_q,    gnt0_d;
   logic          gnt1_q,    gnt1_d;
   logic          done0_q,   done0_d;
   logic          done1_q,   done1_d;
   logic [15:0]   rdata_q,   rdata_d;
   logic          err_q,     err_d;
   logic          busy_q,    busy_d;
   logic [7:0]    opcode_q,  opcode_d;
   logic [15:0]   bus_out_q, bus_out_d;

   logic arb_vld;
   logic arb_idx;

   fpp_rr_arb2 u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     ({req1, req0}),
      .arb_en_i  (state_q == ST_IDLE),
      .gnt_vld_o (arb_vld),
      .gnt_idx_o (arb_idx)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      result_d  = result_q;
      timer_d   = timer_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      done0_d   = 1'b0;
      done1_d   = 1'b0;
      rdata_d   = rdata_q;
      err_d     = err_q;
      opcode_d  = opcode_q;
      bus_out_d = bus_out_q;

      case (state_q)
         ST_IDLE: begin
            if (arb_vld) begin
               state_d   = ST_ISSUE;
               owner_d   = arb_idx;
               gnt0_d    = ~arb_idx;
               gnt1_d    = arb_idx;
               opcode_d  = arb_idx ? op1 : op0;
               bus_out_d = arb_idx ? wdata1 : wdata0;
            end
         end

         ST_ISSUE: begin
            state_d = ST_WAIT;
            timer_d = '0;
         end

         ST_WAIT: begin
            // Last value the processor drove wins, including the value
            // present on the same edge as fpp_done.
            if (fpp_flag) begin
               result_d = fpp_bus_in;
            end
            // fpp_done outranks a timeout landing on the same cycle.
            if (fpp_done) begin
               state_d  = ST_RESP;
               done0_d  = ~owner_q;
               done1_d  = owner_q;
               rdata_d  = result_d;
               err_d    = 1'b0;
               opcode_d = IDLE_OPCODE;
            end else if (timer_q == TIMER_MAX) begin
               state_d  = ST_RESP;
               done0_d  = ~owner_q;
               done1_d  = owner_q;
               result_d = TIMEOUT_RESULT;
               rdata_d  = TIMEOUT_RESULT;
               err_d    = 1'b1;
               opcode_d = IDLE_OPCODE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d  = ST_IDLE;
            opcode_d = IDLE_OPCODE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         owner_q   <= 1'b0;
         result_q  <= '0;
         timer_q   <= '0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         opcode_q  <= IDLE_OPCODE;
         bus_out_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         result_q  <= result_d;
         timer_q   <= timer_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         done0_q   <= done0_d;
         done1_q   <= done1_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         opcode_q  <= opcode_d;
         bus_out_q <= bus_out_d;
      end
   end

   // Bus enable is decoded from state so that reset releases the bus at
   // once, and so that the arbiter backs off in the same cycle the
   // processor raises fpp_flag.
   assign fpp_bus_oe  = (state_q == ST_ISSUE) ||
                        ((state_q == ST_WAIT) && !fpp_flag);

   assign gnt0        = gnt0_q;
   assign gnt1        = gnt1_q;
   assign done0       = done0_q;
   assign done1       = done1_q;
   assign rdata       = rdata_q;
   assign err         = err_q;
   assign busy        = busy_q;
   assign fpp_opcode  = opcode_q;
   assign fpp_bus_out = bus_out_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fpp_op_arbiter.sv
module tb_fpp_op_arbiter;
   import fpp_ctrl_pkg::*;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   always #5 clk = ~clk;

   logic        req0 = 1'b0, req1 = 1'b0;
   logic [7:0]  op0 = '0, op1 = '0;
   logic [15:0] wdata0 = '0, wdata1 = '0;
   logic [15:0] fpp_bus_in = '0;
   logic        fpp_flag = 1'b0, fpp_done = 1'b0;
   logic        gnt0, gnt1, done0, done1, err, busy, fpp_bus_oe;
   logic [15:0] rdata, fpp_bus_out;
   logic [7:0]  fpp_opcode;
   fpp_state_e  dbg_state;

   fpp_op_arbiter #(.TIMEOUT(8), .IDLE_OPCODE(8'h00)) dut (
      .clk         (clk),
      .rst         (rst),
      .req0        (req0),
      .req1        (req1),
      .op0         (op0),
      .op1         (op1),
      .wdata0      (wdata0),
      .wdata1      (wdata1),
      .gnt0        (gnt0),
      .gnt1        (gnt1),
      .done0       (done0),
      .done1       (done1),
      .rdata       (rdata),
      .err         (err),
      .busy        (busy),
      .fpp_opcode  (fpp_opcode),
      .fpp_bus_out (fpp_bus_out),
      .fpp_bus_oe  (fpp_bus_oe),
      .fpp_bus_in  (fpp_bus_in),
      .fpp_flag    (fpp_flag),
      .fpp_done    (fpp_done),
      .dbg_state_o (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;
   logic [0:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic wait_gnt(input string tag);
      int n;
      n = 0;
      step();
      while (!(gnt0 || gnt1) && n < 6) begin
         step();
         n++;
      end
      chk(tag, {31'b0, gnt0 | gnt1}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [0:0] exp_idx;

      // Reset values
      rst = 1'b0;
      step();
      step();
      chk("rst_gnt0",   {31'b0, gnt0}, 0);
      chk("rst_gnt1",   {31'b0, gnt1}, 0);
      chk("rst_done",   {30'b0, done1, done0}, 0);
      chk("rst_err",    {31'b0, err}, 0);
      chk("rst_busy",   {31'b0, busy}, 0);
      chk("rst_rdata",  {16'b0, rdata}, 0);
      chk("rst_opcode", {24'b0, fpp_opcode}, 32'h00);
      chk("rst_oe",     {31'b0, fpp_bus_oe}, 0);
      chk("rst_busout", {16'b0, fpp_bus_out}, 0);
      chk("rst_state",  32'(dbg_state), 32'(ST_IDLE));
      rst = 1'b1;
      step();

      // Single request
      req0 = 1'b1; op0 = 8'h16; wdata0 = 16'h3C00;
      step();                                   // ISSUE
      chk("t1_gnt0",   {31'b0, gnt0}, 1);
      chk("t1_gnt1",   {31'b0, gnt1}, 0);
      chk("t1_op_iss", {24'b0, fpp_opcode}, 32'h16);
      chk("t1_busout", {16'b0, fpp_bus_out}, 32'h3C00);
      chk("t1_oe_iss", {31'b0, fpp_bus_oe}, 1);
      chk("t1_busy",   {31'b0, busy}, 1);
      req0 = 1'b0;
      step();                                   // WAIT, first cycle
      chk("t1_gnt_pulse", {31'b0, gnt0}, 0);
      chk("t1_op_wait",   {24'b0, fpp_opcode}, 32'h16);
      chk("t1_oe_wait",   {31'b0, fpp_bus_oe}, 1);
      fpp_flag = 1'b1; fpp_bus_in = 16'h4000;
      #1 chk("t1_oe_flag", {31'b0, fpp_bus_oe}, 0);
      step();
      chk("t1_op_wait2", {24'b0, fpp_opcode}, 32'h16);
      fpp_flag = 1'b0; fpp_done = 1'b1;
      step();                                   // RESP
      fpp_done = 1'b0;
      chk("t1_done0",   {31'b0, done0}, 1);
      chk("t1_done1",   {31'b0, done1}, 0);
      chk("t1_rdata",   {16'b0, rdata}, 32'h4000);
      chk("t1_err",     {31'b0, err}, 0);
      chk("t1_op_resp", {24'b0, fpp_opcode}, 32'h00);
      chk("t1_oe_resp", {31'b0, fpp_bus_oe}, 0);
      step();                                   // IDLE
      chk("t1_done_pulse", {31'b0, done0}, 0);
      chk("t1_idle_busy",  {31'b0, busy}, 0);

      // Fairness: both held for four operations, pointer fresh from reset
      do_reset();
      exp_q.push_back(1'b0); exp_q.push_back(1'b1);
      exp_q.push_back(1'b0); exp_q.push_back(1'b1);
      req0 = 1'b1; op0 = 8'h21; wdata0 = 16'h1111;
      req1 = 1'b1; op1 = 8'h32; wdata1 = 16'h2222;
      for (int k = 0; k < 4; k++) begin
         exp_idx = exp_q.pop_front();
         wait_gnt($sformatf("fair_gnt_seen%0d", k));
         chk($sformatf("fair_gnt0_%0d", k), {31'b0, gnt0}, {31'b0, ~exp_idx});
         chk($sformatf("fair_gnt1_%0d", k), {31'b0, gnt1}, {31'b0, exp_idx});
         chk($sformatf("fair_op_%0d", k), {24'b0, fpp_opcode},
             exp_idx ? 32'h32 : 32'h21);
         step();
         fpp_flag = 1'b1; fpp_bus_in = 16'hA000 + 16'(k);
         step();
         fpp_flag = 1'b0; fpp_done = 1'b1;
         step();
         fpp_done = 1'b0;
         chk($sformatf("fair_done0_%0d", k), {31'b0, done0}, {31'b0, ~exp_idx});
         chk($sformatf("fair_done1_%0d", k), {31'b0, done1}, {31'b0, exp_idx});
         chk($sformatf("fair_rdata_%0d", k), {16'b0, rdata}, 32'hA000 + k);
      end
      req0 = 1'b0; req1 = 1'b0;
      step();

      // Bus contention: fpp_flag toggling during WAIT
      req1 = 1'b1; op1 = 8'h5A; wdata1 = 16'hBEEF;
      wait_gnt("bus_gnt");
      chk("bus_gnt1", {31'b0, gnt1}, 1);
      req1 = 1'b0;
      step();                                   // WAIT
      begin
         logic [5:0] pat;
         pat = 6'b101101;                       // cycle i uses pat[i]
         for (int i = 0; i < 6; i++) begin
            fpp_flag = pat[i]; fpp_bus_in = 16'h7000 + 16'(i);
            #1 chk($sformatf("bus_oe_%0d", i), {31'b0, fpp_bus_oe}, {31'b0, ~pat[i]});
            step();
         end
      end
      fpp_flag = 1'b0; fpp_done = 1'b1;
      step();
      fpp_done = 1'b0;
      chk("bus_done1", {31'b0, done1}, 1);
      chk("bus_rdata", {16'b0, rdata}, 32'h7005);
      step();

      // Timeout (TIMEOUT = 8)
      req1 = 1'b1; op1 = 8'h4B; wdata1 = 16'h0001;
      wait_gnt("to_gnt");
      req1 = 1'b0;
      step();                                   // WAIT entry cycle
      repeat (8) step();
      chk("to_no_done_early", {31'b0, done1}, 0);
      chk("to_busy",          {31'b0, busy}, 1);
      step();                                   // entry + 9
      chk("to_done1",  {31'b0, done1}, 1);
      chk("to_done0",  {31'b0, done0}, 0);
      chk("to_err",    {31'b0, err}, 1);
      chk("to_rdata",  {16'b0, rdata}, 32'hFFFF);
      chk("to_opcode", {24'b0, fpp_opcode}, 32'h00);
      step();
      chk("to_idle",     32'(dbg_state), 32'(ST_IDLE));
      chk("to_idle_op",  {24'b0, fpp_opcode}, 32'h00);

      // Coincident fpp_done and timeout
      req0 = 1'b1; op0 = 8'h6C; wdata0 = 16'h0002;
      wait_gnt("co_gnt");
      req0 = 1'b0;
      step();                                   // entry
      fpp_flag = 1'b1; fpp_bus_in = 16'h1234;
      step();                                   // entry + 1
      fpp_flag = 1'b0;
      repeat (7) step();                        // entry + 8, timer at limit
      chk("co_no_done_yet", {31'b0, done0}, 0);
      fpp_done = 1'b1;
      step();
      fpp_done = 1'b0;
      chk("co_done0", {31'b0, done0}, 1);
      chk("co_err",   {31'b0, err}, 0);
      chk("co_rdata", {16'b0, rdata}, 32'h1234);
      step();

      // Reset mid-operation with req1 pending
      req0 = 1'b1; op0 = 8'h77; wdata0 = 16'h5555;
      wait_gnt("rm_gnt");
      chk("rm_gnt0", {31'b0, gnt0}, 1);
      req0 = 1'b0; req1 = 1'b1; op1 = 8'h99; wdata1 = 16'h6666;
      step();                                   // WAIT
      chk("rm_oe_wait", {31'b0, fpp_bus_oe}, 1);
      rst = 1'b0;
      #1;
      chk("rm_oe",    {31'b0, fpp_bus_oe}, 0);
      chk("rm_busy",  {31'b0, busy}, 0);
      chk("rm_state", 32'(dbg_state), 32'(ST_IDLE));
      step();
      chk("rm_no_done_a", {30'b0, done1, done0}, 0);
      step();
      chk("rm_no_done_b", {30'b0, done1, done0}, 0);
      rst = 1'b1;
      wait_gnt("rm_regnt");
      chk("rm_gnt1",    {31'b0, gnt1}, 1);
      chk("rm_gnt0_lo", {31'b0, gnt0}, 0);
      chk("rm_op",      {24'b0, fpp_opcode}, 32'h99);
      req1 = 1'b0;
      step();
      fpp_done = 1'b1;
      step();
      fpp_done = 1'b0;
      chk("rm_done1", {31'b0, done1}, 1);
      chk("rm_err",   {31'b0, err}, 0);
      step();

      // Stray fpp_done in IDLE is ignored
      fpp_done = 1'b1;
      step();
      fpp_done = 1'b0;
      chk("stray_done", {30'b0, done1, done0}, 0);
      chk("stray_busy", {31'b0, busy}, 0);

      // ---------------- report ----------------
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fpp_op_arbiter.md
# fpp_op_arbiter

Two-port round-robin arbiter and operation sequencer for the 16-bit floating-point processor. It accepts operation requests (opcode plus one 16-bit operand) from two independent requesters and grants the processor to one of them at a time. While an operation runs it holds the opcode stable, drives or releases the processor's shared data bus according to the processor flag, and captures the result. It returns completion, result and timeout status to the granted requester, and sits between the host-side requesters and the processor's opcode/bus pins.

## Interface
- `TIMEOUT`, 64: maximum WAIT cycles before an operation is abandoned.
- `IDLE_OPCODE`, 8'h00: opcode driven to the processor when no operation is active.

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `req0`, `req1`  in  1  operation request; held until the matching grant
- `op0`, `op1`  in  8  opcode: function[7:4], SRC[3:2], DST[1:0]
- `wdata0`, `wdata1`  in  16  operand presented to the processor bus
- `gnt0`, `gnt1`  out  1  one-cycle pulse: request accepted, inputs latched
- `done0`, `done1`  out  1  one-cycle pulse: operation finished
- `rdata`  out  16  last captured result; valid with `doneN`, held until next completion
- `err`  out  1  with `doneN`: operation timed out
- `busy`  out  1  high in every state except IDLE
- `fpp_opcode`  out  8  opcode to processor
- `fpp_bus_out`  out  16  value to drive on the processor data bus
- `fpp_bus_oe`  out  1  tristate enable for `fpp_bus_out`; the top level owns the tristate
- `fpp_bus_in`  in  16  processor data bus sampled value
- `fpp_flag`  in  1  high while the processor drives the bus
- `fpp_done`  in  1  one-cycle pulse when the processor returns to its fetch state

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any `reqN` is high, select a requester and latch its `opN`/`wdataN`, then go to ISSUE.
  - When both requesters are high, the one not granted last wins. The round-robin pointer resets to favour requester 0.
- **ISSUE** (1 cycle):
  - `gntN` pulses for the selected requester.
  - `fpp_opcode` = latched op.
  - `fpp_bus_out` = latched operand, `fpp_bus_oe` = 1.
  - Go to WAIT.
- **WAIT:**
  - `fpp_opcode` stays equal to the latched op.
  - `fpp_bus_oe` = ~`fpp_flag`. The arbiter never drives while the processor drives.
  - Every cycle with `fpp_flag` = 1 loads `fpp_bus_in` into the result register (last value wins).
  - On `fpp_done`, go to RESP with `err` = 0.
  - The timer counts WAIT cycles. When it reaches `TIMEOUT` without `fpp_done`, go to RESP with `err` = 1 and result = 16'hFFFF.
  - If `fpp_done` and the timeout coincide, `fpp_done` takes priority.
- **RESP** (1 cycle):
  - `doneN` pulses for the granted requester; `rdata` and `err` are valid.
  - `fpp_opcode` = `IDLE_OPCODE`, `fpp_bus_oe` = 0.
  - Go to IDLE.
- **Outside an operation:** `fpp_opcode` = `IDLE_OPCODE` and `fpp_bus_oe` = 0 in IDLE and RESP.
- **Requests during an operation:** requests arriving while busy wait. A `reqN` still high in IDLE after its own `doneN` counts as a new request.
- **Stray inputs:** a `fpp_done` seen outside WAIT is ignored. `fpp_flag` outside WAIT is ignored.

## Timing
- **Reset values** (async, `rst` = 0):
  - State IDLE, pointer favouring requester 0.
  - `gnt*` = 0, `done*` = 0, `err` = 0, `busy` = 0, `rdata` = 0.
  - `fpp_opcode` = `IDLE_OPCODE`, `fpp_bus_oe` = 0, `fpp_bus_out` = 0, timer = 0.
- **Reset mid-operation:** abandon the operation with no `doneN`, release the bus immediately, and resume in IDLE after release.
- **Grant and completion timing:**
  - A request sampled in IDLE at edge N gives `gntN` high in cycle N+1 (ISSUE) and WAIT from N+2.
  - `fpp_done` sampled at edge M gives `doneN` in cycle M+1 and IDLE at M+2.
  - Minimum request-to-done latency is 4 cycles when `fpp_done` arrives on the first WAIT cycle.
  - Back-to-back operations start 1 cycle after RESP.
- **Timer:** width $clog2(TIMEOUT+1), cleared on entry to WAIT, saturates at `TIMEOUT`. A timed-out operation has `doneN` exactly `TIMEOUT`+1 cycles after WAIT entry.
- **Output registering:** all outputs are registered except `fpp_bus_oe`. In WAIT, `fpp_bus_oe` is combinational from state and `fpp_flag` so that the bus is released in the same cycle the processor drives.

## Structure
- Package `fpp_ctrl_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - the `IDLE_OPCODE` default;
  - a 16'hFFFF timeout-result constant;
  - opcode field localparams (FUNC = [7:4], SRC = [3:2], DST = [1:0]).
- Sub-module `fpp_rr_arb2` contains the 2-way round-robin selector with its pointer register, advancing on grant. The FSM, timer and bus control stay in the top module.

## Test plan
- **Single request:** reset, then `req0`=1, `op0`=8'h16, `wdata0`=16'h3C00; processor model raises `fpp_flag` with bus 16'h4000, then pulses `fpp_done`. Required: `gnt0` 1 cycle later, `fpp_opcode`=8'h16 held through WAIT, `done0` with `rdata`=16'h4000, `err`=0.
- **Fairness:** `req0` and `req1` both held continuously for 4 operations. Required: grant order 0,1,0,1, each `fpp_done` answered with the matching `doneN` only.
- **Bus contention:** during WAIT toggle `fpp_flag`. Required: `fpp_bus_oe` = ~`fpp_flag` in every cycle, never 1 while `fpp_flag`=1.
- **Timeout:** `TIMEOUT`=8 with `fpp_done` never asserted. Required: `done1` 9 cycles after WAIT entry, `err`=1, `rdata`=16'hFFFF, then return to IDLE with `fpp_opcode`=`IDLE_OPCODE`.
- **Coincident done and timeout:** `fpp_done` on the cycle the timer reaches `TIMEOUT`. Required: `err`=0 and the captured result is returned.
- **Reset mid-operation:** assert `rst` during WAIT. Required: immediate `fpp_bus_oe`=0 and `busy`=0, no `doneN`; after release a pending `req1` is granted normally.
